kdtree_load_ctrl: RTL and testbench
===================================

// Module: kdtree_load_ctrl
// PURPOSE
// - Sequences the 11-bit input-FIFO word stream after a load_kdtree pulse into three targets:
//   - internal-node table
//   - leaf patch memory
//   - query patch memory
// - Assembles multi-word records and issues one write strobe per record.
// - Flags tree_loaded / query_loaded; top-level control gates fsm_start on query_loaded.
// - Sits between the io-side async input FIFO (read side) and the storage arrays.
// PARAMETERS
// - DATA_WIDTH  11   width of one FIFO word / one patch element
// - PATCH_SIZE  5    data words per patch
// - LEAF_SIZE   8    patches per leaf
// - NUM_LEAVES  64   leaves; NUM_NODES = NUM_LEAVES-1 (localparam)
// - NUM_QUERYS  494  query patches (26x19)
// - IDX_WIDTH   3    width of node split-dimension index
// PORTS
// - wb_clk_i       in   1                      clock
// - wb_rst_i       in   1                      reset, asynchronous, active-high
// - load_kdtree    in   1                      1-cycle pulse: (re)start load sequence
// - fifo_rdata     in   DATA_WIDTH             FIFO head word (first-word-fall-through)
// - fifo_rempty_n  in   1                      FIFO head valid
// - fifo_deq       out  1                      pop head this cycle (combinational)
// - node_wen       out  1                      internal-node write strobe
// - node_waddr     out  $clog2(NUM_NODES)      node index
// - node_idx       out  IDX_WIDTH              split dimension
// - node_median    out  DATA_WIDTH             split value
// - leaf_wen       out  1                      leaf patch write strobe
// - leaf_waddr     out  $clog2(NUM_LEAVES)     leaf number
// - leaf_slot      out  $clog2(LEAF_SIZE)      patch slot within leaf
// - leaf_wpatch    out  PATCH_SIZE*DATA_WIDTH  patch; element 0 in LSBs
// - leaf_wpidx     out  DATA_WIDTH             original-image patch index
// - query_wen      out  1                      query patch write strobe
// - query_waddr    out  $clog2(NUM_QUERYS)     query number
// - query_wpatch   out  PATCH_SIZE*DATA_WIDTH  query patch; element 0 in LSBs
// - tree_loaded    out  1                      nodes+leaves complete
// - query_loaded   out  1                      all queries complete
// BEHAVIOUR
// - Reset: state IDLE; all counters 0; all outputs 0.
// - States and transitions:
//   - IDLE -> NODES on load_kdtree
//   - NODES: 2*NUM_NODES words, per node {idx, median}; -> LEAVES after last
//   - LEAVES: NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1) words, per patch 5 data + 1 pidx;
//     slot fills 0..7 then leaf increments; -> QUERIES after last
//   - QUERIES: NUM_QUERYS*PATCH_SIZE words; -> DONE after last
//   - DONE: hold until load_kdtree
// - Dequeue:
//   - fifo_deq = fifo_rempty_n & state in {NODES, LEAVES, QUERIES} & ~load_kdtree
//   - Word consumed only when fifo_deq=1; an empty FIFO stalls all counters (gaps are legal).
// - Record assembly:
//   - Words shift into a staging register.
//   - node_idx takes fifo_rdata[IDX_WIDTH-1:0]; upper bits are ignored.
// - Write timing:
//   - Strobe, address and data are registered.
//   - *_wen pulses exactly 1 cycle, the cycle after the record's final word is dequeued.
//   - Address and data are valid with the strobe and held until the next record.
// - Flags:
//   - tree_loaded rises the cycle after the last leaf write strobe.
//   - query_loaded rises with entry to DONE, on the same edge as the last query_wen.
//   - Both flags are sticky until load_kdtree or reset.
// - load_kdtree in any state:
//   - Clears counters, staging and flags; enters NODES next cycle.
//   - No word is dequeued that cycle; a partially assembled record is discarded.
// - Words arriving in IDLE/DONE stay in the FIFO (fifo_deq=0).
// - Reset mid-load: async return to IDLE; the partial record is lost, with no write strobe.
// - Counters are exact-terminal compares: no wrap, no overflow.
// STRUCTURE
// - Shared package kdtree_pkg holds:
//   - DATA_WIDTH, PATCH_SIZE, LEAF_SIZE, NUM_LEAVES, NUM_NODES, NUM_QUERYS
//   - typedef patch_t (PATCH_SIZE x DATA_WIDTH packed)
//   - enum load_state_e {IDLE, NODES, LEAVES, QUERIES, DONE}
// - Sub-module patch_assembler (word counter + shift staging, parameterised record length)
//   is instantiated for leaf (6 words) and query (5 words) records.
// - Node records (2 words) are handled inline.
// TESTING
// - Reset, then 2 node words {2, 700} -> one node_wen, waddr=0, idx=2, median=700; no leaf/query strobe.
// - Full 126+3072+2470-word stream with random FIFO gaps:
//   - 63 node_wen, 512 leaf_wen, 494 query_wen
//   - leaf record 9 has waddr=1, slot=1
//   - last query waddr=493
//   - tree_loaded, query_loaded end at 1
// - Leaf patch words 1,2,3,4,5 then pidx 42 -> leaf_wpatch elements = 1..5 (LSB first), leaf_wpidx=42.
// - load_kdtree pulsed mid-LEAVES with rempty_n=1:
//   - fifo_deq=0 that cycle; flags cleared
//   - next node_wen at waddr=0
// - Async wb_rst_i asserted between clock edges during QUERIES -> outputs 0 immediately; state IDLE; no strobe for the partial query.
// - 10 extra words after DONE -> fifo_deq stays 0; no write strobes.

Source files
------------

// File: rtl/kdtree_pkg.sv
// Shared sizes, patch type and load-sequence states for the kd-tree load controller.
package kdtree_pkg;

  localparam int unsigned DATA_WIDTH = 11;
  localparam int unsigned PATCH_SIZE = 5;
  localparam int unsigned LEAF_SIZE  = 8;
  localparam int unsigned NUM_LEAVES = 64;
  localparam int unsigned NUM_NODES  = NUM_LEAVES - 1;
  localparam int unsigned NUM_QUERYS = 494;
  localparam int unsigned IDX_WIDTH  = 3;

  localparam int unsigned NODE_AW    = $clog2(NUM_NODES);
  localparam int unsigned LEAF_AW    = $clog2(NUM_LEAVES);
  localparam int unsigned SLOT_W     = $clog2(LEAF_SIZE);
  localparam int unsigned QUERY_AW   = $clog2(NUM_QUERYS);
  localparam int unsigned LEAF_WORDS = PATCH_SIZE + 1;
  localparam int unsigned PATCH_W    = PATCH_SIZE * DATA_WIDTH;

  // Element 0 sits in the least significant DATA_WIDTH bits.
  typedef logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] patch_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NODES   = 3'd1,
    LEAVES  = 3'd2,
    QUERIES = 3'd3,
    DONE    = 3'd4
  } load_state_e;

endpackage

// File: rtl/kdtree_load_ctrl_if.sv
// FIFO read side plus node/leaf/query write ports and load-status flags.
interface kdtree_load_ctrl_if;
  import kdtree_pkg::*;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rempty_n;
  logic                  fifo_deq;

  logic                  node_wen;
  logic [NODE_AW-1:0]    node_waddr;
  logic [IDX_WIDTH-1:0]  node_idx;
  logic [DATA_WIDTH-1:0] node_median;

  logic                  leaf_wen;
  logic [LEAF_AW-1:0]    leaf_waddr;
  logic [SLOT_W-1:0]     leaf_slot;
  patch_t                leaf_wpatch;
  logic [DATA_WIDTH-1:0] leaf_wpidx;

  logic                  query_wen;
  logic [QUERY_AW-1:0]   query_waddr;
  patch_t                query_wpatch;

  logic                  tree_loaded;
  logic                  query_loaded;

  modport master (
    input  fifo_rdata, fifo_rempty_n,
    output fifo_deq,
    output node_wen, node_waddr, node_idx, node_median,
    output leaf_wen, leaf_waddr, leaf_slot, leaf_wpatch, leaf_wpidx,
    output query_wen, query_waddr, query_wpatch,
    output tree_loaded, query_loaded
  );

  modport slave (
    output fifo_rdata, fifo_rempty_n,
    input  fifo_deq,
    input  node_wen, node_waddr, node_idx, node_median,
    input  leaf_wen, leaf_waddr, leaf_slot, leaf_wpatch, leaf_wpidx,
    input  query_wen, query_waddr, query_wpatch,
    input  tree_loaded, query_loaded
  );

endinterface

// File: rtl/kdtree_load_ctrl_patch_assembler.sv
// Collects RECORD_WORDS consecutive FIFO words into one record, first word in the LSBs.
module kdtree_load_ctrl_patch_assembler
  import kdtree_pkg::*;
#(
  parameter int unsigned RECORD_WORDS = PATCH_SIZE
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 en,
  input  logic [DATA_WIDTH-1:0]                word,
  output logic                                 last_c,
  output logic [RECORD_WORDS*DATA_WIDTH-1:0]   record_c
);

  localparam int unsigned CNT_W   = $clog2(RECORD_WORDS);
  localparam int unsigned REC_W   = RECORD_WORDS * DATA_WIDTH;
  localparam int unsigned STAGE_W = REC_W - DATA_WIDTH;

  logic [CNT_W-1:0]   cnt_q;
  logic [STAGE_W-1:0] stage_q;

  // The final word is taken straight from the FIFO head so the record completes with no extra cycle.
  assign last_c   = en && (cnt_q == CNT_W'(RECORD_WORDS - 1));
  assign record_c = {word, stage_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      stage_q <= '0;
    end else if (clr) begin
      cnt_q   <= '0;
      stage_q <= '0;
    end else if (en) begin
      stage_q <= record_c[REC_W-1:DATA_WIDTH];
      cnt_q   <= last_c ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/kdtree_load_ctrl.sv
// Steers the post-load FIFO word stream into node, leaf and query write ports.
// Each completed record produces one registered write strobe with held address/data.
module kdtree_load_ctrl
  import kdtree_pkg::*;
(
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               load_kdtree,
  kdtree_load_ctrl_if.master bus
);

  load_state_e state_q, state_d;

  logic deq_c, node_en_c, leaf_en_c, query_en_c;
  logic node_last_c, leaf_end_c, query_end_c;
  logic leaf_last_c, query_last_c;

  logic [LEAF_WORDS*DATA_WIDTH-1:0] leaf_rec_c;
  logic [PATCH_W-1:0]               query_rec_c;

  logic                  node_word_q;
  logic [IDX_WIDTH-1:0]  node_stage_q;
  logic [NODE_AW-1:0]    node_cnt_q;
  logic [SLOT_W-1:0]     slot_cnt_q;
  logic [LEAF_AW-1:0]    leaf_cnt_q;
  logic [QUERY_AW-1:0]   query_cnt_q;

  // A load pulse owns its cycle: nothing is popped while the sequence restarts.
  assign deq_c        = bus.fifo_rempty_n && !load_kdtree &&
                        (state_q inside {NODES, LEAVES, QUERIES});
  assign bus.fifo_deq = deq_c;
  assign node_en_c    = deq_c && (state_q == NODES);
  assign leaf_en_c    = deq_c && (state_q == LEAVES);
  assign query_en_c   = deq_c && (state_q == QUERIES);

  kdtree_load_ctrl_patch_assembler #(.RECORD_WORDS(LEAF_WORDS)) u_leaf_asm (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clr      (load_kdtree),
    .en       (leaf_en_c),
    .word     (bus.fifo_rdata),
    .last_c   (leaf_last_c),
    .record_c (leaf_rec_c)
  );

  kdtree_load_ctrl_patch_assembler #(.RECORD_WORDS(PATCH_SIZE)) u_query_asm (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clr      (load_kdtree),
    .en       (query_en_c),
    .word     (bus.fifo_rdata),
    .last_c   (query_last_c),
    .record_c (query_rec_c)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-section terminal detection.
  always_comb begin
    state_d     = state_q;
    node_last_c = 1'b0;
    leaf_end_c  = 1'b0;
    query_end_c = 1'b0;
    case (state_q)
      IDLE: ;
      NODES: begin
        node_last_c = node_en_c && node_word_q &&
                      (node_cnt_q == NODE_AW'(NUM_NODES - 1));
        if (node_last_c) state_d = LEAVES;
      end
      LEAVES: begin
        leaf_end_c = leaf_last_c &&
                     (leaf_cnt_q == LEAF_AW'(NUM_LEAVES - 1)) &&
                     (slot_cnt_q == SLOT_W'(LEAF_SIZE - 1));
        if (leaf_end_c) state_d = QUERIES;
      end
      QUERIES: begin
        query_end_c = query_last_c && (query_cnt_q == QUERY_AW'(NUM_QUERYS - 1));
        if (query_end_c) state_d = DONE;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (load_kdtree) state_d = NODES;
  end

  // Record counters, write ports and sticky completion flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      node_word_q      <= 1'b0;
      node_stage_q     <= '0;
      node_cnt_q       <= '0;
      slot_cnt_q       <= '0;
      leaf_cnt_q       <= '0;
      query_cnt_q      <= '0;
      bus.node_wen     <= 1'b0;
      bus.node_waddr   <= '0;
      bus.node_idx     <= '0;
      bus.node_median  <= '0;
      bus.leaf_wen     <= 1'b0;
      bus.leaf_waddr   <= '0;
      bus.leaf_slot    <= '0;
      bus.leaf_wpatch  <= '0;
      bus.leaf_wpidx   <= '0;
      bus.query_wen    <= 1'b0;
      bus.query_waddr  <= '0;
      bus.query_wpatch <= '0;
      bus.tree_loaded  <= 1'b0;
      bus.query_loaded <= 1'b0;
    end else if (load_kdtree) begin
      node_word_q      <= 1'b0;
      node_stage_q     <= '0;
      node_cnt_q       <= '0;
      slot_cnt_q       <= '0;
      leaf_cnt_q       <= '0;
      query_cnt_q      <= '0;
      bus.node_wen     <= 1'b0;
      bus.leaf_wen     <= 1'b0;
      bus.query_wen    <= 1'b0;
      bus.tree_loaded  <= 1'b0;
      bus.query_loaded <= 1'b0;
    end else begin
      bus.node_wen  <= 1'b0;
      bus.leaf_wen  <= 1'b0;
      bus.query_wen <= 1'b0;

      if (node_en_c) begin
        node_word_q <= ~node_word_q;
        if (!node_word_q) begin
          node_stage_q <= bus.fifo_rdata[IDX_WIDTH-1:0];
        end else begin
          bus.node_wen    <= 1'b1;
          bus.node_waddr  <= node_cnt_q;
          bus.node_idx    <= node_stage_q;
          bus.node_median <= bus.fifo_rdata;
          if (!node_last_c) node_cnt_q <= node_cnt_q + 1'b1;
        end
      end

      if (leaf_last_c) begin
        bus.leaf_wen    <= 1'b1;
        bus.leaf_waddr  <= leaf_cnt_q;
        bus.leaf_slot   <= slot_cnt_q;
        bus.leaf_wpatch <= patch_t'(leaf_rec_c[PATCH_W-1:0]);
        bus.leaf_wpidx  <= leaf_rec_c[LEAF_WORDS*DATA_WIDTH-1 -: DATA_WIDTH];
        if (!leaf_end_c) begin
          if (slot_cnt_q == SLOT_W'(LEAF_SIZE - 1)) begin
            slot_cnt_q <= '0;
            leaf_cnt_q <= leaf_cnt_q + 1'b1;
          end else begin
            slot_cnt_q <= slot_cnt_q + 1'b1;
          end
        end
      end

      if (query_last_c) begin
        bus.query_wen    <= 1'b1;
        bus.query_waddr  <= query_cnt_q;
        bus.query_wpatch <= patch_t'(query_rec_c);
        if (query_end_c) bus.query_loaded <= 1'b1;
        else             query_cnt_q      <= query_cnt_q + 1'b1;
      end

      // The tree flag trails the final leaf strobe by one cycle.
      if (bus.leaf_wen &&
          (bus.leaf_waddr == LEAF_AW'(NUM_LEAVES - 1)) &&
          (bus.leaf_slot == SLOT_W'(LEAF_SIZE - 1)))
        bus.tree_loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kdtree_load_ctrl.sv
// Directed bench for kdtree_load_ctrl: FWFT FIFO model, write-port logger, per-scenario checks.
`timescale 1ns/1ps
module tb_kdtree_load_ctrl;
  import kdtree_pkg::*;

  localparam int TOTAL_WORDS = 126 + 3072 + 2470;

  typedef struct packed {
    logic [NODE_AW-1:0]    waddr;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] median;
  } node_rec_t;
  typedef struct packed {
    logic [LEAF_AW-1:0]    waddr;
    logic [SLOT_W-1:0]     slot;
    patch_t                patch;
    logic [DATA_WIDTH-1:0] pidx;
  } leaf_rec_t;
  typedef struct packed {
    logic [QUERY_AW-1:0] waddr;
    patch_t              patch;
  } query_rec_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic load = 1'b0;

  kdtree_load_ctrl_if bus();
  kdtree_load_ctrl dut (.wb_clk_i(clk), .wb_rst_i(rst), .load_kdtree(load), .bus(bus));

  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] fifo_q[$];
  bit gap_en = 1'b0;
  node_rec_t  node_log[$];
  leaf_rec_t  leaf_log[$];
  query_rec_t query_log[$];
  logic tl_at_strobe = 1'b1, tl_after = 1'b0, ql_at_strobe = 1'b0, tl_pend = 1'b0;
  int checks = 0, failures = 0;

  function automatic logic [DATA_WIDTH-1:0] stream_word(input int k);
    int r, e;
    if (k < 126) begin
      if (k % 2 == 0) return 11'h7F8 | 11'((k / 2) % 8);
      return 11'((k / 2) * 3 + 1);
    end
    k = k - 126;
    if (k < 3072) begin
      r = k / 6; e = k % 6;
      if (e == 5) return 11'((r + 42) % 2048);
      return 11'((r * 7 + e + 1) % 2048);
    end
    k = k - 3072;
    r = k / 5; e = k % 5;
    return 11'((r * 5 + e + 100) % 2048);
  endfunction

  task automatic drive_head(input bit gap);
    bus.fifo_rempty_n = (fifo_q.size() != 0) && !gap;
    bus.fifo_rdata    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // FIFO head changes at the falling edge; a pop is taken just before the rising edge.
  always begin : fifo_driver
    bit gap;
    @(negedge clk);
    gap = gap_en && ($urandom_range(0, 3) == 0);
    drive_head(gap);
    #2 drive_head(gap);
    #2 if (bus.fifo_deq === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
  end

  always @(posedge clk) begin : write_logger
    #1;
    if (tl_pend) begin tl_after = bus.tree_loaded; tl_pend = 1'b0; end
    if (bus.node_wen === 1'b1) node_log.push_back({bus.node_waddr, bus.node_idx, bus.node_median});
    if (bus.leaf_wen === 1'b1) begin
      leaf_log.push_back({bus.leaf_waddr, bus.leaf_slot, bus.leaf_wpatch, bus.leaf_wpidx});
      if (bus.leaf_waddr == 6'd63 && bus.leaf_slot == 3'd7) begin
        tl_at_strobe = bus.tree_loaded; tl_pend = 1'b1;
      end
    end
    if (bus.query_wen === 1'b1) begin
      query_log.push_back({bus.query_waddr, bus.query_wpatch});
      if (bus.query_waddr == 9'd493) ql_at_strobe = bus.query_loaded;
    end
  end

  task automatic push_stream(input int n);
    for (int k = 0; k < n; k++) fifo_q.push_back(stream_word(k));
  endtask

  task automatic pulse_load();
    @(negedge clk); #1 load = 1'b1;
    @(negedge clk); #1 load = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while (fifo_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    ok = (fifo_q.size() == 0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.node_wen !== 1'b0) begin failures++; $display("FAIL reset_node_wen got=%b exp=0", bus.node_wen); end
    checks++; if (bus.leaf_wen !== 1'b0) begin failures++; $display("FAIL reset_leaf_wen got=%b exp=0", bus.leaf_wen); end
    checks++; if (bus.query_wen !== 1'b0) begin failures++; $display("FAIL reset_query_wen got=%b exp=0", bus.query_wen); end
    checks++; if (bus.tree_loaded !== 1'b0 || bus.query_loaded !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.tree_loaded, bus.query_loaded); end
    checks++; if (bus.fifo_deq !== 1'b0) begin failures++; $display("FAIL reset_deq got=%b exp=0", bus.fifo_deq); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_single_node();
    int n0 = node_log.size(), l0 = leaf_log.size(), q0 = query_log.size();
    bit ok;
    node_rec_t nr;
    fifo_q.push_back(11'd2); fifo_q.push_back(11'd700);
    repeat (4) @(negedge clk);
    checks++; if (fifo_q.size() != 2) begin failures++; $display("FAIL idle_holds_words got=%0d exp=2", fifo_q.size()); end
    pulse_load();
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_node_drain timeout left=%0d exp=0", fifo_q.size()); end
    checks++; if (node_log.size() - n0 != 1) begin failures++; $display("FAIL single_node_count got=%0d exp=1", node_log.size() - n0); end
    nr = (node_log.size() > n0) ? node_log[n0] : '0;
    checks++; if (nr !== {6'd0, 3'd2, 11'd700}) begin failures++; $display("FAIL single_node_rec got=%0d/%0d/%0d exp=0/2/700", nr.waddr, nr.idx, nr.median); end
    checks++; if (leaf_log.size() != l0 || query_log.size() != q0) begin failures++; $display("FAIL single_node_other got=%0d/%0d exp=0/0", leaf_log.size() - l0, query_log.size() - q0); end
  endtask

  task automatic test_full_stream();
    int n0, l0, q0;
    bit ok;
    node_rec_t nr; leaf_rec_t lr; query_rec_t qr;
    pulse_load();
    n0 = node_log.size(); l0 = leaf_log.size(); q0 = query_log.size();
    gap_en = 1'b1;
    push_stream(TOTAL_WORDS);
    wait_drain(12000, ok);
    gap_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL full_drain timeout left=%0d exp=0", fifo_q.size()); end
    checks++; if (node_log.size() - n0 != 63) begin failures++; $display("FAIL full_node_count got=%0d exp=63", node_log.size() - n0); end
    checks++; if (leaf_log.size() - l0 != 512) begin failures++; $display("FAIL full_leaf_count got=%0d exp=512", leaf_log.size() - l0); end
    checks++; if (query_log.size() - q0 != 494) begin failures++; $display("FAIL full_query_count got=%0d exp=494", query_log.size() - q0); end
    nr = (node_log.size() > n0 + 5) ? node_log[n0 + 5] : '0;
    checks++; if (nr !== {6'd5, 3'd5, 11'd16}) begin failures++; $display("FAIL node5_rec got=%0d/%0d/%0d exp=5/5/16", nr.waddr, nr.idx, nr.median); end
    lr = (leaf_log.size() > l0) ? leaf_log[l0] : '0;
    checks++; if (lr.patch !== {11'd5, 11'd4, 11'd3, 11'd2, 11'd1}) begin failures++; $display("FAIL leaf0_patch got=%h exp=%h", lr.patch, {11'd5, 11'd4, 11'd3, 11'd2, 11'd1}); end
    checks++; if (lr.pidx !== 11'd42 || lr.waddr !== 6'd0 || lr.slot !== 3'd0) begin failures++; $display("FAIL leaf0_pidx got=%0d@%0d/%0d exp=42@0/0", lr.pidx, lr.waddr, lr.slot); end
    lr = (leaf_log.size() > l0 + 9) ? leaf_log[l0 + 9] : '0;
    checks++; if (lr.waddr !== 6'd1 || lr.slot !== 3'd1) begin failures++; $display("FAIL leaf9_addr got=%0d/%0d exp=1/1", lr.waddr, lr.slot); end
    lr = (leaf_log.size() > l0 + 511) ? leaf_log[l0 + 511] : '0;
    checks++; if (lr.waddr !== 6'd63 || lr.slot !== 3'd7) begin failures++; $display("FAIL leaf511_addr got=%0d/%0d exp=63/7", lr.waddr, lr.slot); end
    qr = (query_log.size() > q0 + 493) ? query_log[q0 + 493] : '0;
    checks++; if (qr.waddr !== 9'd493) begin failures++; $display("FAIL last_query_addr got=%0d exp=493", qr.waddr); end
    checks++; if (qr.patch !== {11'd521, 11'd520, 11'd519, 11'd518, 11'd517}) begin failures++; $display("FAIL last_query_patch got=%h exp=%h", qr.patch, {11'd521, 11'd520, 11'd519, 11'd518, 11'd517}); end
    checks++; if (bus.tree_loaded !== 1'b1 || bus.query_loaded !== 1'b1) begin failures++; $display("FAIL full_flags got=%b%b exp=11", bus.tree_loaded, bus.query_loaded); end
    checks++; if (tl_at_strobe !== 1'b0 || tl_after !== 1'b1) begin failures++; $display("FAIL tree_flag_timing got=%b%b exp=01", tl_at_strobe, tl_after); end
    checks++; if (ql_at_strobe !== 1'b1) begin failures++; $display("FAIL query_flag_timing got=%b exp=1", ql_at_strobe); end
    checks++; if (dut.state_q !== DONE) begin failures++; $display("FAIL full_state got=%0d exp=%0d", dut.state_q, DONE); end
  endtask

  task automatic test_load_clears_flags();
    pulse_load();
    checks++; if (bus.tree_loaded !== 1'b0 || bus.query_loaded !== 1'b0) begin failures++; $display("FAIL load_clears_flags got=%b%b exp=00", bus.tree_loaded, bus.query_loaded); end
    checks++; if (dut.state_q !== NODES) begin failures++; $display("FAIL load_enters_nodes got=%0d exp=%0d", dut.state_q, NODES); end
  endtask

  task automatic test_load_mid_leaves();
    int n0, l0;
    bit ok;
    node_rec_t nr;
    l0 = leaf_log.size();
    push_stream(126 + 21);
    wait_drain(400, ok);
    checks++; if (!ok || dut.state_q !== LEAVES) begin failures++; $display("FAIL mid_leaves_setup got=%0d exp=%0d", dut.state_q, LEAVES); end
    checks++; if (leaf_log.size() - l0 != 3) begin failures++; $display("FAIL mid_leaves_count got=%0d exp=3", leaf_log.size() - l0); end
    n0 = node_log.size(); l0 = leaf_log.size();
    @(negedge clk); #1;
    load = 1'b1;
    fifo_q.push_back(11'd5); fifo_q.push_back(11'd321);
    for (int k = 2; k < 30; k++) fifo_q.push_back(stream_word(k));
    #2;
    checks++; if (bus.fifo_deq !== 1'b0) begin failures++; $display("FAIL deq_during_load got=%b exp=0", bus.fifo_deq); end
    @(negedge clk); #1 load = 1'b0;
    checks++; if (fifo_q.size() != 30) begin failures++; $display("FAIL load_cycle_pop got=%0d exp=30", fifo_q.size()); end
    wait_drain(200, ok);
    checks++; if (node_log.size() - n0 != 15) begin failures++; $display("FAIL reload_node_count got=%0d exp=15", node_log.size() - n0); end
    nr = (node_log.size() > n0) ? node_log[n0] : '0;
    checks++; if (nr !== {6'd0, 3'd5, 11'd321}) begin failures++; $display("FAIL reload_node0 got=%0d/%0d/%0d exp=0/5/321", nr.waddr, nr.idx, nr.median); end
    nr = (node_log.size() > n0 + 1) ? node_log[n0 + 1] : '0;
    checks++; if (nr !== {6'd1, 3'd1, 11'd4}) begin failures++; $display("FAIL reload_node1 got=%0d/%0d/%0d exp=1/1/4", nr.waddr, nr.idx, nr.median); end
    checks++; if (leaf_log.size() != l0) begin failures++; $display("FAIL partial_leaf_dropped got=%0d exp=0", leaf_log.size() - l0); end
  endtask

  task automatic test_async_reset();
    int q0;
    bit ok;
    pulse_load();
    q0 = query_log.size();
    push_stream(126 + 3072 + 13);
    wait_drain(5000, ok);
    checks++; if (query_log.size() - q0 != 2 || bus.query_waddr !== 9'd1) begin failures++; $display("FAIL pre_reset_query got=%0d@%0d exp=2@1", query_log.size() - q0, bus.query_waddr); end
    checks++; if (bus.tree_loaded !== 1'b1) begin failures++; $display("FAIL pre_reset_tree got=%b exp=1", bus.tree_loaded); end
    @(negedge clk); #2 rst = 1'b1;
    #1;
    checks++; if (bus.tree_loaded !== 1'b0 || bus.node_waddr !== '0 || bus.leaf_waddr !== '0 || bus.query_waddr !== '0) begin failures++; $display("FAIL async_reset_outputs got=%b/%0d/%0d/%0d exp=0/0/0/0", bus.tree_loaded, bus.node_waddr, bus.leaf_waddr, bus.query_waddr); end
    checks++; if (bus.leaf_wpatch !== '0 || bus.leaf_wpidx !== '0 || bus.node_median !== '0) begin failures++; $display("FAIL async_reset_data got=%h/%0d/%0d exp=0/0/0", bus.leaf_wpatch, bus.leaf_wpidx, bus.node_median); end
    checks++; if (dut.state_q !== IDLE || bus.fifo_deq !== 1'b0) begin failures++; $display("FAIL async_reset_state got=%0d/%b exp=%0d/0", dut.state_q, bus.fifo_deq, IDLE); end
    fifo_q.push_back(11'd9); fifo_q.push_back(11'd10);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (query_log.size() - q0 != 2) begin failures++; $display("FAIL partial_query_no_strobe got=%0d exp=2", query_log.size() - q0); end
    checks++; if (fifo_q.size() != 2 || dut.state_q !== IDLE) begin failures++; $display("FAIL post_reset_idle got=%0d/%0d exp=2/%0d", fifo_q.size(), dut.state_q, IDLE); end
    fifo_q.delete();
  endtask

  task automatic test_words_after_done();
    int n0, l0, q0;
    bit ok;
    pulse_load();
    push_stream(TOTAL_WORDS);
    wait_drain(8000, ok);
    checks++; if (!ok || dut.state_q !== DONE) begin failures++; $display("FAIL second_load_done got=%0d exp=%0d", dut.state_q, DONE); end
    n0 = node_log.size(); l0 = leaf_log.size(); q0 = query_log.size();
    for (int k = 0; k < 10; k++) fifo_q.push_back(11'(k + 1));
    repeat (20) @(negedge clk);
    #3;
    checks++; if (bus.fifo_deq !== 1'b0 || fifo_q.size() != 10) begin failures++; $display("FAIL done_holds_words got=%b/%0d exp=0/10", bus.fifo_deq, fifo_q.size()); end
    checks++; if (node_log.size() != n0 || leaf_log.size() != l0 || query_log.size() != q0) begin failures++; $display("FAIL done_no_strobes got=%0d/%0d/%0d exp=0/0/0", node_log.size() - n0, leaf_log.size() - l0, query_log.size() - q0); end
    checks++; if (bus.query_loaded !== 1'b1 || bus.tree_loaded !== 1'b1) begin failures++; $display("FAIL done_flags_sticky got=%b%b exp=11", bus.tree_loaded, bus.query_loaded); end
    fifo_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_node();
    test_full_stream();
    test_load_clears_flags();
    test_load_mid_leaves();
    test_async_reset();
    test_words_after_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
